// File: rtl/gfx_pkg.sv
// Shared graphics definitions: screen geometry defaults, colour width,
// fill FSM states and the standard colour constants.
package gfx_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int COLOUR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FINISH
    } fill_state_t;

    localparam logic [COLOUR_W_DEF-1:0] BLACK = 3'd0;
    localparam logic [COLOUR_W_DEF-1:0] WHITE = 3'd7;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y walker over a latched rectangle [xs..xe] x [ys..ye].
// Holds position while not advanced; flags the bottom-right pixel.
module raster_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic           advance,
    input  logic [X_W-1:0] xs,
    input  logic [Y_W-1:0] ys,
    input  logic [X_W-1:0] xe,
    input  logic [Y_W-1:0] ye,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last_pixel
);

    logic [X_W-1:0] x_start;
    logic [X_W-1:0] x_end;
    logic [Y_W-1:0] y_end;

    assign last_pixel = (x == x_end) && (y == y_end);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            x_start <= '0;
            x_end   <= '0;
            y_end   <= '0;
        end else if (load) begin
            x       <= xs;
            y       <= ys;
            x_start <= xs;
            x_end   <= xe;
            y_end   <= ye;
        end else if (advance && !last_pixel) begin
            if (x != x_end) begin
                x <= x + X_W'(1);
            end else begin
                x <= x_start;
                y <= y + Y_W'(1);
            end
        end
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle / full-screen fill engine: clips the requested region to the
// screen and streams one pixel write per accepted cycle to the framebuffer.
module rect_fill_engine
    import gfx_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = COLOUR_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               full_screen,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W-1:0]     w,
    input  logic [Y_W-1:0]     h,
    input  logic [COLOR_W-1:0] colour_in,
    input  logic               plot_ready,
    output logic               plot,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] colour,
    output logic               busy,
    output logic               done
);

    // One extra bit so limits equal to 2^X_W / 2^Y_W still compare correctly.
    localparam logic [X_W:0] X_LIMIT = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W:0] X_LAST  = (X_W+1)'(SCREEN_W - 1);
    localparam logic [Y_W:0] Y_LAST  = (Y_W+1)'(SCREEN_H - 1);

    fill_state_t    state;
    logic [X_W:0]   x_sum;
    logic [Y_W:0]   y_sum;
    logic [X_W-1:0] xs, xe;
    logic [Y_W-1:0] ys, ye;
    logic           empty;
    logic           load;
    logic           advance;
    logic           last_pixel;

    // NOTE: every signal gets a default at the top of always_comb, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        x_sum = {1'b0, x0} + {1'b0, w} - (X_W+1)'(1);
        y_sum = {1'b0, y0} + {1'b0, h} - (Y_W+1)'(1);
        xs    = x0;
        ys    = y0;
        xe    = (x_sum > X_LAST) ? X_LAST[X_W-1:0] : x_sum[X_W-1:0];
        ye    = (y_sum > Y_LAST) ? Y_LAST[Y_W-1:0] : y_sum[Y_W-1:0];
        empty = (w == '0) || (h == '0) ||
                ({1'b0, x0} >= X_LIMIT) || ({1'b0, y0} >= Y_LIMIT);
        if (full_screen) begin
            xs    = '0;
            ys    = '0;
            xe    = X_LAST[X_W-1:0];
            ye    = Y_LAST[Y_W-1:0];
            empty = 1'b0;
        end
    end

    assign load    = (state == IDLE) && start && !empty;
    assign advance = plot && plot_ready;

    raster_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_raster (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .advance    (advance),
        .xs         (xs),
        .ys         (ys),
        .xe         (xe),
        .ye         (ye),
        .x          (x),
        .y          (y),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            colour <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        colour <= colour_in;
                        if (empty) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAW;
                            plot  <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (advance && last_pixel) begin
                        state <= FINISH;
                        plot  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    // start is deliberately not sampled here.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: full-screen clear, small rectangles,
// clipping, empty regions, back-pressure and mid-fill reset.
module tb_rect_fill_engine;
    import gfx_pkg::*;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           full_screen = 1'b0;
    logic [X_W-1:0] x0 = '0;
    logic [Y_W-1:0] y0 = '0;
    logic [X_W-1:0] w = '0;
    logic [Y_W-1:0] h = '0;
    logic [C_W-1:0] colour_in = '0;
    logic           plot_ready = 1'b1;
    logic           plot;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;

    rect_fill_engine #(
        .SCREEN_W (160),
        .SCREEN_H (120),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOR_W  (C_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .full_screen (full_screen),
        .x0          (x0),
        .y0          (y0),
        .w           (w),
        .h           (h),
        .colour_in   (colour_in),
        .plot_ready  (plot_ready),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Request a fill, then scramble the request inputs right after the accept edge.
    task automatic do_start(input bit fs, input int sx, input int sy, input int sw,
                            input int sh, input int col);
        @(negedge clock);
        full_screen = fs;
        x0          = X_W'(sx);
        y0          = Y_W'(sy);
        w           = X_W'(sw);
        h           = Y_W'(sh);
        colour_in   = C_W'(col);
        start       = 1'b1;
        @(posedge clock);
        #1;
        start       = 1'b0;
        full_screen = 1'b0;
        x0          = X_W'($urandom);
        y0          = Y_W'($urandom);
        w           = X_W'($urandom);
        h           = Y_W'($urandom);
        colour_in   = C_W'($urandom);
    endtask

    // Observe one fill from the cycle after accept until done, comparing the
    // stream against a raster walk over the hand-computed clipped bounds.
    task automatic drain(input string tag, input int xs, input int ys, input int xe,
                         input int ye, input int col, input bit empty, input bit rnd,
                         input int pulse_at, input int budget);
        int n_exp;
        int ex, ey, hx, hy;
        int n_plots, seq_bad, col_bad, hs_bad, stall_bad, oob;
        int first_plot, done_at, last_xfer, last_x, last_y, exp_done;
        bit held;
        n_exp = empty ? 0 : (xe - xs + 1) * (ye - ys + 1);
        ex = xs; ey = ys; hx = 0; hy = 0;
        n_plots = 0; seq_bad = 0; col_bad = 0; hs_bad = 0; stall_bad = 0; oob = 0;
        first_plot = -1; done_at = -1; last_xfer = 0; last_x = -1; last_y = -1;
        held = 1'b0;
        for (int n = 1; n <= budget && done_at < 0; n++) begin
            @(negedge clock);
            if (n == pulse_at) begin
                start = 1'b1;
                full_screen = 1'b1;
            end else if (n == pulse_at + 1) begin
                start = 1'b0;
                full_screen = 1'b0;
            end
            if (done) begin
                done_at = n;
                if (busy || plot) hs_bad++;
            end else begin
                if (busy !== !empty || plot !== !empty) hs_bad++;
                if (plot) begin
                    if (first_plot < 0) first_plot = n;
                    if (x >= 160 || y >= 120) oob++;
                    if (held && (x != hx || y != hy)) stall_bad++;
                    if (colour != C_W'(col)) col_bad++;
                    plot_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (plot_ready) begin
                        n_plots++;
                        if (x != ex || y != ey) seq_bad++;
                        last_x = x; last_y = y; last_xfer = n;
                        if (ex < xe) ex++;
                        else begin ex = xs; ey++; end
                        held = 1'b0;
                    end else begin
                        held = 1'b1; hx = x; hy = y;
                    end
                end
            end
        end
        plot_ready = 1'b1;
        start = 1'b0;
        full_screen = 1'b0;
        exp_done = rnd ? last_xfer + 1 : n_exp + 1;
        check({tag, " plot_count"}, n_plots, n_exp);
        check({tag, " raster_seq_errs"}, seq_bad, 0);
        check({tag, " colour_errs"}, col_bad, 0);
        check({tag, " handshake_errs"}, hs_bad, 0);
        check({tag, " stall_moves"}, stall_bad, 0);
        check({tag, " out_of_screen"}, oob, 0);
        check({tag, " done_cycle"}, done_at, exp_done);
        if (!empty) begin
            check({tag, " first_plot_cycle"}, first_plot, 1);
            check({tag, " last_x"}, last_x, xe);
            check({tag, " last_y"}, last_y, ye);
        end
        @(negedge clock);
        check({tag, " done_one_cycle"}, int'(done), 0);
        check({tag, " busy_after"}, int'(busy), 0);
        check({tag, " plot_after"}, int'(plot), 0);
    endtask

    initial begin
        int stray;

        repeat (2) @(negedge clock);
        check("reset plot", int'(plot), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset x", int'(x), 0);
        check("reset y", int'(y), 0);
        check("reset colour", int'(colour), 0);
        reset = 1'b0;
        @(negedge clock);

        do_start(1'b1, 77, 33, 9, 9, int'(BLACK));
        drain("full", 0, 0, 159, 119, int'(BLACK), 1'b0, 1'b0, -1, 20000);

        do_start(1'b0, 10, 5, 3, 2, 5);
        drain("rect", 10, 5, 12, 6, 5, 1'b0, 1'b0, -1, 50);

        do_start(1'b0, 158, 118, 5, 4, 3);
        drain("clip", 158, 118, 159, 119, 3, 1'b0, 1'b0, -1, 50);

        do_start(1'b0, 10, 5, 0, 4, 2);
        drain("w0", 0, 0, 0, 0, 2, 1'b1, 1'b0, -1, 10);

        do_start(1'b0, 200, 5, 4, 4, 2);
        drain("x200", 0, 0, 0, 0, 2, 1'b1, 1'b0, -1, 10);

        do_start(1'b0, 10, 120, 4, 4, 2);
        drain("y120", 0, 0, 0, 0, 2, 1'b1, 1'b0, -1, 10);

        do_start(1'b0, 50, 60, 4, 2, 6);
        drain("bp", 50, 60, 53, 61, 6, 1'b0, 1'b1, 3, 300);

        // Reset during the second row of a 10x10 fill at (20,30).
        do_start(1'b0, 20, 30, 10, 10, 4);
        repeat (13) @(negedge clock);
        check("pre_reset x", int'(x), 22);
        check("pre_reset y", int'(y), 31);
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset plot", int'(plot), 0);
        check("mid_reset busy", int'(busy), 0);
        check("mid_reset done", int'(done), 0);
        check("mid_reset x", int'(x), 0);
        check("mid_reset y", int'(y), 0);
        reset = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clock);
            if (done || plot || busy) stray++;
        end
        check("post_reset idle", stray, 0);

        do_start(1'b0, 0, 0, 2, 2, int'(WHITE));
        drain("fresh", 0, 0, 1, 1, int'(WHITE), 1'b0, 1'b0, -1, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
